// File: rtl/stopwatch_bcd_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd_counter
//   MM:SS stopwatch counting whole seconds as four BCD digits. The clock
//   divider output (scaledclk) is sampled as data and its rising edges are
//   detected in the system clock domain. A prescaler turns TICKS_PER_UNIT
//   edges into one increment. A start/stop/lap/clear state machine gates
//   the counting and drives the divider's enable and clear inputs.
//
// Ports
//   clock        system clock, all logic on posedge
//   reset        asynchronous active-low reset
//   scaledclk    divider output, synchronous to clock, treated as data
//   start_stop   command pulse: toggle run/pause
//   lap          command pulse: freeze/unfreeze the display
//   clear        command pulse: zero the count and go idle
//   div_enable   divider enable, high in RUN and LAP
//   div_clear    registered one-cycle pulse to the divider reset
//   running      high in RUN and LAP
//   disp_digits  {min_tens, min_ones, sec_tens, sec_ones}, BCD
//   rollover     one-cycle pulse after the count wraps 59:59 -> 00:00
// -----------------------------------------------------------------------------
module stopwatch_bcd_counter #(
    parameter int unsigned TICKS_PER_UNIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scaledclk,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic        div_enable,
    output logic        div_clear,
    output logic        running,
    output logic [15:0] disp_digits,
    output logic        rollover
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [15:0] LAST_TICK = 16'(TICKS_PER_UNIT - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic        sclk_q_r;
    logic        tick_s;
    logic        counting_s;
    logic [15:0] presc_r;
    logic [15:0] presc_next_s;
    logic        inc_s;
    logic [15:0] digits_r;
    logic [15:0] digits_inc_s;
    logic        wrap_s;
    logic [15:0] lap_r;
    logic        lap_capture_s;
    logic        div_clear_r;
    logic        rollover_r;

    // Advance MM:SS by one second. Returns {wrap, next_digits}. Comparing
    // with >= keeps any out-of-range digit from ever being held.
    function automatic logic [16:0] bcd_step(input logic [15:0] d);
        logic [3:0] so;
        logic [3:0] st;
        logic [3:0] mo;
        logic [3:0] mt;
        logic       wrap;
        so   = d[3:0];
        st   = d[7:4];
        mo   = d[11:8];
        mt   = d[15:12];
        wrap = 1'b0;
        if (so >= 4'd9) begin
            so = 4'd0;
            if (st >= 4'd5) begin
                st = 4'd0;
                if (mo >= 4'd9) begin
                    mo = 4'd0;
                    if (mt >= 4'd5) begin
                        mt   = 4'd0;
                        wrap = 1'b1;
                    end else begin
                        mt = mt + 4'd1;
                    end
                end else begin
                    mo = mo + 4'd1;
                end
            end else begin
                st = st + 4'd1;
            end
        end else begin
            so = so + 4'd1;
        end
        return {wrap, mt, mo, st, so};
    endfunction

    // Edge detect and prescaler: gating uses the current state, so an
    // increment still lands in the cycle a start_stop leaves RUN/LAP.
    always_comb begin
        tick_s       = scaledclk & ~sclk_q_r;
        counting_s   = (state_r == RUN) || (state_r == LAP);
        presc_next_s = presc_r;
        inc_s        = 1'b0;
        if (tick_s && counting_s) begin
            if (presc_r >= LAST_TICK) begin
                presc_next_s = 16'd0;
                inc_s        = 1'b1;
            end else begin
                presc_next_s = presc_r + 16'd1;
            end
        end else begin
            presc_next_s = presc_r;
        end
    end

    assign {wrap_s, digits_inc_s} = bcd_step(digits_r);

    // Command decode with priority clear > start_stop > lap.
    always_comb begin
        state_next_s  = state_r;
        lap_capture_s = 1'b0;
        if (clear) begin
            state_next_s = IDLE;
        end else if (start_stop) begin
            case (state_r)
                IDLE:    state_next_s = RUN;
                RUN:     state_next_s = PAUSE;
                LAP:     state_next_s = PAUSE;
                PAUSE:   state_next_s = RUN;
                default: state_next_s = IDLE;
            endcase
        end else if (lap) begin
            case (state_r)
                RUN: begin
                    state_next_s  = LAP;
                    lap_capture_s = 1'b1;
                end
                LAP:     state_next_s = RUN;
                IDLE:    state_next_s = IDLE;
                PAUSE:   state_next_s = PAUSE;
                default: state_next_s = IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State register and scaledclk history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            sclk_q_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            sclk_q_r <= scaledclk;
        end
    end

    // Prescaler, live digits and lap latch; clear overrides a same-cycle inc.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_r  <= 16'd0;
            digits_r <= 16'h0000;
            lap_r    <= 16'h0000;
        end else if (clear) begin
            presc_r  <= 16'd0;
            digits_r <= 16'h0000;
            lap_r    <= 16'h0000;
        end else begin
            presc_r  <= presc_next_s;
            digits_r <= inc_s ? digits_inc_s : digits_r;
            // digits_r is still the pre-increment value here.
            lap_r    <= lap_capture_s ? digits_r : lap_r;
        end
    end

    // Registered divider clear and rollover pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_clear_r <= 1'b0;
            rollover_r  <= 1'b0;
        end else begin
            div_clear_r <= clear;
            rollover_r  <= inc_s & wrap_s & ~clear;
        end
    end

    assign div_enable  = counting_s;
    assign running     = counting_s;
    assign div_clear   = div_clear_r;
    assign rollover    = rollover_r;
    assign disp_digits = (state_r == LAP) ? lap_r : digits_r;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// -----------------------------------------------------------------------------
// Bench for stopwatch_bcd_counter. Two instances (TICKS_PER_UNIT 1 and 3)
// share one stimulus stream. A model keeps elapsed time as a plain integer
// count of seconds plus a tick count, and converts to MM:SS BCD only when
// comparing. Inputs change on the falling edge; outputs are compared on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_bcd_counter;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    logic        clock      = 1'b0;
    logic        reset      = 1'b0;
    logic        scaledclk  = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap        = 1'b0;
    logic        clear      = 1'b0;
    logic [1:0]  d_den;
    logic [1:0]  d_dclr;
    logic [1:0]  d_run;
    logic [1:0]  d_roll;
    logic [15:0] d_disp0;
    logic [15:0] d_disp1;

    int n_chk    = 0;
    int n_pass   = 0;
    int roll_cnt = 0;

    int m_tpu   [2] = '{1, 3};
    int m_state [2];
    int m_secs  [2];
    int m_presc [2];
    int m_lap   [2];
    int m_roll  [2];
    int m_dclr  [2];
    bit m_prev;

    stopwatch_bcd_counter #(.TICKS_PER_UNIT(1)) dut1 (
        .clock(clock), .reset(reset), .scaledclk(scaledclk),
        .start_stop(start_stop), .lap(lap), .clear(clear),
        .div_enable(d_den[0]), .div_clear(d_dclr[0]), .running(d_run[0]),
        .disp_digits(d_disp0), .rollover(d_roll[0])
    );

    stopwatch_bcd_counter #(.TICKS_PER_UNIT(3)) dut3 (
        .clock(clock), .reset(reset), .scaledclk(scaledclk),
        .start_stop(start_stop), .lap(lap), .clear(clear),
        .div_enable(d_den[1]), .div_clear(d_dclr[1]), .running(d_run[1]),
        .disp_digits(d_disp1), .rollover(d_roll[1])
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        m = s / 60;
        return {4'(m / 10), 4'(m % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = S_IDLE;
            m_secs[k]  = 0;
            m_presc[k] = 0;
            m_lap[k]   = 0;
            m_roll[k]  = 0;
            m_dclr[k]  = 0;
        end
        m_prev = 1'b0;
    endtask

    // Apply one clock edge worth of the stopwatch rules to the model.
    task automatic model_update();
        bit tick;
        tick   = scaledclk && !m_prev;
        m_prev = scaledclk;
        for (int k = 0; k < 2; k++) begin
            int  old;
            int  st;
            bit  inc;
            old = m_secs[k];
            st  = m_state[k];
            inc = 1'b0;
            if (tick && (st == S_RUN || st == S_LAP)) begin
                m_presc[k]++;
                if (m_presc[k] == m_tpu[k]) begin
                    m_presc[k] = 0;
                    inc        = 1'b1;
                end
            end
            m_roll[k] = 0;
            m_dclr[k] = clear ? 1 : 0;
            if (clear) begin
                m_secs[k]  = 0;
                m_presc[k] = 0;
                m_lap[k]   = 0;
                m_state[k] = S_IDLE;
            end else begin
                if (inc) begin
                    m_secs[k] = (old + 1) % 3600;
                    if (old == 3599) m_roll[k] = 1;
                end
                if (start_stop) begin
                    m_state[k] = (st == S_RUN || st == S_LAP) ? S_PAUSE : S_RUN;
                end else if (lap) begin
                    if (st == S_RUN) begin
                        m_state[k] = S_LAP;
                        m_lap[k]   = old;
                    end else if (st == S_LAP) begin
                        m_state[k] = S_RUN;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] exp_disp;
            logic [15:0] act_disp;
            bit          exp_run;
            exp_disp = (m_state[k] == S_LAP) ? to_bcd(m_lap[k]) : to_bcd(m_secs[k]);
            act_disp = (k == 0) ? d_disp0 : d_disp1;
            exp_run  = (m_state[k] == S_RUN || m_state[k] == S_LAP);
            chk($sformatf("disp_digits[T=%0d]", m_tpu[k]), act_disp, exp_disp);
            chk($sformatf("running[T=%0d]", m_tpu[k]), 16'(d_run[k]), 16'(exp_run));
            chk($sformatf("div_enable[T=%0d]", m_tpu[k]), 16'(d_den[k]), 16'(exp_run));
            chk($sformatf("div_clear[T=%0d]", m_tpu[k]), 16'(d_dclr[k]), 16'(m_dclr[k]));
            chk($sformatf("rollover[T=%0d]", m_tpu[k]), 16'(d_roll[k]), 16'(m_roll[k]));
        end
        if (d_roll[0]) roll_cnt++;
    endtask

    // One clock cycle: drive inputs, step the model on the edge, compare.
    task automatic cyc(input bit sc, input bit ss, input bit lp, input bit cl);
        scaledclk  = sc;
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        @(posedge clock);
        model_update();
        @(negedge clock);
        compare_all();
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, " disp0"}, d_disp0, 16'h0000);
        chk({name, " disp1"}, d_disp1, 16'h0000);
        chk({name, " flags"}, 16'({d_den, d_dclr, d_run, d_roll}), 16'h0000);
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        check_all_zero("reset_state");
        reset = 1'b1;

        // 75 edges at one tick per second -> 01:15
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        edges(75);
        chk("plan1 disp T=1", d_disp0, 16'h0115);
        chk("plan1 disp T=3", d_disp1, 16'h0025);
        chk("plan1 running", 16'(d_run[0]), 16'h0001);
        chk("plan1 div_enable", 16'(d_den[0]), 16'h0001);

        // Pause keeps the partial second of the prescaler
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        edges(5);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        edges(10);
        chk("plan2 paused running", 16'(d_run[1]), 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        edges(1);
        chk("plan2 disp T=3", d_disp1, 16'h0002);
        chk("plan2 disp T=1", d_disp0, 16'h0006);

        // Wrap 59:59 -> 00:00 with exactly one rollover pulse
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        roll_cnt = 0;
        edges(3598);
        chk("plan3 preload", d_disp0, 16'h5958);
        edges(2);
        chk("plan3 wrapped", d_disp0, 16'h0000);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("plan3 rollover pulses", 16'(roll_cnt), 16'h0001);

        // Lap freezes the display while counting continues
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        edges(10);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        edges(5);
        chk("plan4 frozen T=1", d_disp0, 16'h0010);
        chk("plan4 frozen T=3", d_disp1, 16'h0003);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("plan4 released T=1", d_disp0, 16'h0015);
        chk("plan4 released T=3", d_disp1, 16'h0005);

        // clear beats a coincident start_stop
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        edges(42);
        chk("plan5 at 00:42", d_disp0, 16'h0042);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("plan5 disp", d_disp0, 16'h0000);
        chk("plan5 div_clear", 16'(d_dclr[0]), 16'h0001);
        chk("plan5 div_enable", 16'(d_den[0]), 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("plan5 div_clear done", 16'(d_dclr[0]), 16'h0000);

        // Async reset mid-count, between clock edges
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        edges(207);
        chk("plan6 at 03:27", d_disp0, 16'h0327);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        edges(5);
        chk("plan6 stays stopped", d_disp0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        edges(3);
        chk("plan6 restart T=1", d_disp0, 16'h0003);
        chk("plan6 restart T=3", d_disp1, 16'h0001);

        // Randomized commands and scaledclk against the model
        for (int i = 0; i < 3000; i++) begin
            bit sc;
            bit ss;
            bit lp;
            bit cl;
            sc = 1'($urandom_range(0, 1));
            ss = ($urandom_range(0, 15) == 0);
            lp = ($urandom_range(0, 7) == 0);
            cl = ($urandom_range(0, 63) == 0);
            cyc(sc, ss, lp, cl);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
- Downstream consumer of the 1/100 clock divider output (scaledclk).
- Treats scaledclk as data and detects its rising edges in the system clock domain.
- Counts elapsed time as four BCD digits (MM:SS) under a start/stop/lap/clear state machine.
- Drives the divider's enable and clear inputs; feeds the display digit mux.

Parameters:
TICKS_PER_UNIT, 1, number of scaledclk rising edges per one-second increment (legal range 1..65535)

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-low reset
scaledclk  input  1  divider output, synchronous to clock, treated as data
start_stop  input  1  single-cycle command pulse: toggle run/pause
lap  input  1  single-cycle command pulse: freeze/unfreeze display
clear  input  1  single-cycle command pulse: zero count, go idle
div_enable  output  1  enable to divider; high in RUN and LAP
div_clear  output  1  one-cycle active-high pulse to divider reset, registered
running  output  1  high in RUN and LAP
disp_digits  output  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD, 4 bits each
rollover  output  1  one-cycle pulse when count wraps 59:59 -> 00:00

Behaviour:
- Reset (reset=0, async): state=IDLE, all digits 0, lap latch 0, prescaler 0, edge register 0, div_enable=0, div_clear=0, running=0, rollover=0, disp_digits=16'h0000.
- Edge detect: sclk_q <= scaledclk. tick = scaledclk & ~sclk_q. An increment takes effect on the clock edge after tick is high.
- Prescaler (16-bit):
  - Advances on tick only when state is RUN or LAP.
  - On tick with prescaler == TICKS_PER_UNIT-1: prescaler <= 0 and inc asserts for that cycle.
  - Holds its value in PAUSE, so a partial second is preserved.
- BCD chain on inc:
  - sec_ones 9->0 carries to sec_tens.
  - sec_tens 5->0 carries to min_ones.
  - min_ones 9->0 carries to min_tens.
  - min_tens 5->0 wraps the count to 00:00; rollover=1 for exactly the next cycle.
  - No digit ever holds a value above its limit.
- FSM states: IDLE, RUN, PAUSE, LAP. Command priority when pulses coincide: clear > start_stop > lap.
  - IDLE: start_stop -> RUN. lap is ignored.
  - RUN: start_stop -> PAUSE. lap -> LAP, capturing the current live digits into the lap latch.
  - LAP: start_stop -> PAUSE and releases the freeze. lap -> RUN and releases the freeze. Counting continues while in LAP.
  - PAUSE: start_stop -> RUN. lap is ignored.
  - clear in any state -> IDLE: digits 0, prescaler 0, lap latch 0, and div_clear pulses high for one cycle.
- Same-cycle interactions:
  - An inc that coincides with a start_stop leaving RUN/LAP still updates the count, because increment gating uses the current state.
  - clear overrides a coincident inc; the count becomes 00:00 and rollover is suppressed.
  - The lap latch captures the pre-increment digits when lap and inc coincide.
- disp_digits:
  - Shows the lap latch in LAP and the live digits in all other states.
  - Driven from registers; the display updates in the same cycle the digits update.
- div_enable and running are combinational decodes of the state register. There is no glitch path from the command inputs.
- A command pulse held high for more than one cycle is treated as one command per cycle. Upstream pulse generation is the source's responsibility.
- An async reset asserted mid-count returns every register to its reset value immediately. Leaving reset is synchronous to clock.

Test Plan:
- TICKS_PER_UNIT=1. Reset, start_stop pulse, drive 75 scaledclk rising edges -> disp_digits=16'h0115, running=1, div_enable=1.
- TICKS_PER_UNIT=3. RUN, 5 edges, start_stop to PAUSE, 10 edges, start_stop to RUN, 1 edge -> sec_ones=2. Edges in PAUSE do not count, and the prescaler is retained.
- Preload to 59:58 with 3598 edges, then 2 more edges -> disp_digits=16'h0000 and a single one-cycle rollover pulse.
- RUN at 00:10, lap pulse, 5 edges -> disp_digits stays 16'h0010. Second lap pulse -> disp_digits=16'h0015.
- clear and start_stop in the same cycle during RUN at 00:42 -> state IDLE, disp_digits=16'h0000, div_clear high for one cycle, div_enable=0.
- Assert reset low mid-count at 03:27, asynchronously between clock edges -> all outputs 0 before the next posedge; counting stays stopped after release until a start_stop pulse.
